// File: rtl/proc_controller_gen.sv
// -----------------------------------------------------------------------------
// proc_controller_gen
// Multi-cycle fetch/decode/execute controller for the lab processor, with
// configurable register-file and data-address widths.
//
// Instruction layout (MSB first): opcode[4] | AHI[DATA_ADDR_W] | RD[RF_ADDR_W]
//   RA  = upper RF_ADDR_W bits of AHI, RB = next RF_ADDR_W bits below RA,
//   ALO = low DATA_ADDR_W bits of the instruction.
// Opcodes: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6 LOADI, 7 JMPZ,
//          8-15 trap into ERROR (left only by reset).
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   instruction         instruction-register contents
//   alu_zero            ALU result==0, sampled at the end of JMPZ_B
//   start               resume request while halted
//   ld                  IR load
//   pc_clr/pc_up/pc_ld  PC clear / increment / parallel load (pc_ld_val)
//   d_addr, d_wr        data-RAM address and write enable
//   rf_s                RF write mux: 0 ALU, 1 data RAM, 2 immediate (imm)
//   rf_w_addr/rf_w_wr   RF write port
//   rf_ra_*/rf_rb_*     RF read ports A and B
//   alu_s               ALU select: 0 pass A, 1 add, 2 sub
//   halted, error       status flags, state_o current state code
//   retired_cnt         (only with CTRL_RETIRE_CNT_EN) retired-instruction
//                       counter, saturating at 16'hFFFF
//
// Every output is a flop loaded on the edge that enters a state, so the value
// seen during a state is the value that state calls for. Address and
// immediate registers keep their last value when a state does not drive them.
//
// Optional feature macro: CTRL_RETIRE_CNT_EN.
// DATA_ADDR_W must be >= 2*RF_ADDR_W so that RA and RB both fit inside AHI.
// -----------------------------------------------------------------------------
module proc_controller_gen #(
  parameter int RF_ADDR_W   = 4,
  parameter int DATA_ADDR_W = 8,
  parameter int INIT_CYCLES = 2,
  localparam int INSTR_W    = 4 + RF_ADDR_W + DATA_ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INSTR_W-1:0]     instruction,
  input  logic                   alu_zero,
  input  logic                   start,
  output logic                   ld,
  output logic                   pc_clr,
  output logic                   pc_up,
  output logic                   pc_ld,
  output logic [DATA_ADDR_W-1:0] pc_ld_val,
  output logic [DATA_ADDR_W-1:0] d_addr,
  output logic                   d_wr,
  output logic [1:0]             rf_s,
  output logic [DATA_ADDR_W-1:0] imm,
  output logic [RF_ADDR_W-1:0]   rf_w_addr,
  output logic                   rf_w_wr,
  output logic [RF_ADDR_W-1:0]   rf_ra_addr,
  output logic                   rf_ra_rd,
  output logic [RF_ADDR_W-1:0]   rf_rb_addr,
  output logic                   rf_rb_rd,
  output logic [2:0]             alu_s,
  output logic                   halted,
  output logic                   error,
  output logic [3:0]             state_o
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0]            retired_cnt
`endif
);

  localparam logic [3:0] ST_INIT   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_NOOP   = 4'd3;
  localparam logic [3:0] ST_LOAD_A = 4'd4;
  localparam logic [3:0] ST_LOAD_B = 4'd5;
  localparam logic [3:0] ST_STORE  = 4'd6;
  localparam logic [3:0] ST_ADD    = 4'd7;
  localparam logic [3:0] ST_SUB    = 4'd8;
  localparam logic [3:0] ST_HALT   = 4'd9;
  localparam logic [3:0] ST_LOADI  = 4'd10;
  localparam logic [3:0] ST_JMPZ_A = 4'd11;
  localparam logic [3:0] ST_JMPZ_B = 4'd12;
  localparam logic [3:0] ST_ERROR  = 4'd13;

  localparam int CNT_W = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);

  // Instruction fields
  logic [3:0]             w_opcode;
  logic [RF_ADDR_W-1:0]   w_ra, w_rb, w_rd;
  logic [DATA_ADDR_W-1:0] w_ahi, w_alo;

  assign w_opcode = instruction[INSTR_W-1 -: 4];
  assign w_ra     = instruction[INSTR_W-5 -: RF_ADDR_W];
  assign w_rb     = instruction[INSTR_W-5-RF_ADDR_W -: RF_ADDR_W];
  assign w_rd     = instruction[RF_ADDR_W-1:0];
  assign w_ahi    = instruction[INSTR_W-5:RF_ADDR_W];
  assign w_alo    = instruction[DATA_ADDR_W-1:0];

  logic [3:0]             r_state, w_state;
  logic [CNT_W-1:0]       r_cnt, w_cnt;
  logic                   r_ld, r_pc_clr, r_pc_up, r_pc_ld, r_d_wr;
  logic                   r_rf_w_wr, r_rf_ra_rd, r_rf_rb_rd, r_halted, r_error;
  logic [1:0]             r_rf_s;
  logic [2:0]             r_alu_s;
  logic [DATA_ADDR_W-1:0] r_pc_ld_val, r_d_addr, r_imm;
  logic [RF_ADDR_W-1:0]   r_rf_w_addr, r_rf_ra_addr, r_rf_rb_addr;
  logic                   w_ld, w_pc_clr, w_pc_up, w_pc_ld, w_d_wr;
  logic                   w_rf_w_wr, w_rf_ra_rd, w_rf_rb_rd, w_halted, w_error;
  logic [1:0]             w_rf_s;
  logic [2:0]             w_alu_s;
  logic [DATA_ADDR_W-1:0] w_pc_ld_val, w_d_addr, w_imm;
  logic [RF_ADDR_W-1:0]   w_rf_w_addr, w_rf_ra_addr, w_rf_rb_addr;

  // Next-state logic and INIT cycle counter
  always_comb begin
    w_state = ST_ERROR;
    w_cnt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        if (r_cnt < CNT_W'(INIT_CYCLES)) begin
          w_state = ST_INIT;
          w_cnt   = r_cnt + CNT_W'(1);
        end else begin
          w_state = ST_FETCH;
        end
      end
      ST_FETCH:  w_state = ST_DECODE;
      ST_DECODE: begin
        case (w_opcode)
          4'd0:    w_state = ST_NOOP;
          4'd1:    w_state = ST_STORE;
          4'd2:    w_state = ST_LOAD_A;
          4'd3:    w_state = ST_ADD;
          4'd4:    w_state = ST_SUB;
          4'd5:    w_state = ST_HALT;
          4'd6:    w_state = ST_LOADI;
          4'd7:    w_state = ST_JMPZ_A;
          default: w_state = ST_ERROR;
        endcase
      end
      ST_LOAD_A: w_state = ST_LOAD_B;
      ST_JMPZ_A: w_state = ST_JMPZ_B;
      ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB, ST_LOADI, ST_JMPZ_B:
        w_state = ST_FETCH;
      ST_HALT: begin
        if (start) begin
          w_state = ST_FETCH;
        end else begin
          w_state = ST_HALT;
        end
      end
      ST_ERROR: w_state = ST_ERROR;
      default:  w_state = ST_ERROR;
    endcase
  end

  // Output values for the state being entered
  always_comb begin
    w_ld         = 1'b0;
    w_pc_clr     = 1'b0;
    w_pc_up      = 1'b0;
    w_pc_ld      = 1'b0;
    w_pc_ld_val  = r_pc_ld_val;
    w_d_addr     = r_d_addr;
    w_d_wr       = 1'b0;
    w_rf_s       = 2'd0;
    w_imm        = r_imm;
    w_rf_w_addr  = r_rf_w_addr;
    w_rf_w_wr    = 1'b0;
    w_rf_ra_addr = r_rf_ra_addr;
    w_rf_ra_rd   = 1'b0;
    w_rf_rb_addr = r_rf_rb_addr;
    w_rf_rb_rd   = 1'b0;
    w_alu_s      = 3'd0;
    w_halted     = 1'b0;
    w_error      = 1'b0;
    case (w_state)
      ST_INIT: w_pc_clr = 1'b1;
      ST_FETCH: begin
        w_ld    = 1'b1;
        w_pc_up = 1'b1;
        // A taken jump rides on the FETCH cycle; the PC gives pc_ld priority.
        if ((r_state == ST_JMPZ_B) && alu_zero) begin
          w_pc_ld     = 1'b1;
          w_pc_ld_val = w_alo;
        end else begin
          w_pc_ld     = 1'b0;
        end
      end
      ST_DECODE, ST_NOOP: w_ld = 1'b0;
      ST_LOAD_A, ST_LOAD_B: begin
        w_d_addr    = w_ahi;
        w_rf_w_addr = w_rd;
        w_rf_s      = 2'd1;
        // RAM read data is valid one cycle after the address, so write in B.
        w_rf_w_wr   = (w_state == ST_LOAD_B);
      end
      ST_STORE: begin
        w_rf_ra_addr = w_ra;
        w_rf_ra_rd   = 1'b1;
        w_d_addr     = w_alo;
        w_d_wr       = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        w_rf_ra_addr = w_ra;
        w_rf_rb_addr = w_rb;
        w_rf_ra_rd   = 1'b1;
        w_rf_rb_rd   = 1'b1;
        w_rf_w_addr  = w_rd;
        w_rf_w_wr    = 1'b1;
        w_alu_s      = (w_state == ST_ADD) ? 3'd1 : 3'd2;
      end
      ST_LOADI: begin
        w_imm       = w_ahi;
        w_rf_s      = 2'd2;
        w_rf_w_addr = w_rd;
        w_rf_w_wr   = 1'b1;
      end
      ST_JMPZ_A, ST_JMPZ_B: begin
        w_rf_ra_addr = w_ra;
        w_rf_ra_rd   = 1'b1;
      end
      ST_HALT:  w_halted = 1'b1;
      ST_ERROR: w_error  = 1'b1;
      default:  w_error  = 1'b1;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_cnt        <= '0;
      r_ld         <= 1'b0;
      r_pc_clr     <= 1'b0;
      r_pc_up      <= 1'b0;
      r_pc_ld      <= 1'b0;
      r_pc_ld_val  <= '0;
      r_d_addr     <= '0;
      r_d_wr       <= 1'b0;
      r_rf_s       <= 2'd0;
      r_imm        <= '0;
      r_rf_w_addr  <= '0;
      r_rf_w_wr    <= 1'b0;
      r_rf_ra_addr <= '0;
      r_rf_ra_rd   <= 1'b0;
      r_rf_rb_addr <= '0;
      r_rf_rb_rd   <= 1'b0;
      r_alu_s      <= 3'd0;
      r_halted     <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_ld         <= w_ld;
      r_pc_clr     <= w_pc_clr;
      r_pc_up      <= w_pc_up;
      r_pc_ld      <= w_pc_ld;
      r_pc_ld_val  <= w_pc_ld_val;
      r_d_addr     <= w_d_addr;
      r_d_wr       <= w_d_wr;
      r_rf_s       <= w_rf_s;
      r_imm        <= w_imm;
      r_rf_w_addr  <= w_rf_w_addr;
      r_rf_w_wr    <= w_rf_w_wr;
      r_rf_ra_addr <= w_rf_ra_addr;
      r_rf_ra_rd   <= w_rf_ra_rd;
      r_rf_rb_addr <= w_rf_rb_addr;
      r_rf_rb_rd   <= w_rf_rb_rd;
      r_alu_s      <= w_alu_s;
      r_halted     <= w_halted;
      r_error      <= w_error;
    end
  end

  assign ld         = r_ld;
  assign pc_clr     = r_pc_clr;
  assign pc_up      = r_pc_up;
  assign pc_ld      = r_pc_ld;
  assign pc_ld_val  = r_pc_ld_val;
  assign d_addr     = r_d_addr;
  assign d_wr       = r_d_wr;
  assign rf_s       = r_rf_s;
  assign imm        = r_imm;
  assign rf_w_addr  = r_rf_w_addr;
  assign rf_w_wr    = r_rf_w_wr;
  assign rf_ra_addr = r_rf_ra_addr;
  assign rf_ra_rd   = r_rf_ra_rd;
  assign rf_rb_addr = r_rf_rb_addr;
  assign rf_rb_rd   = r_rf_rb_rd;
  assign alu_s      = r_alu_s;
  assign halted     = r_halted;
  assign error      = r_error;
  assign state_o    = r_state;

`ifdef CTRL_RETIRE_CNT_EN
  logic        w_retire;
  logic [15:0] r_retired_cnt;

  // An instruction retires when an execute state hands back to FETCH
  always_comb begin
    case (r_state)
      ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB, ST_LOADI, ST_JMPZ_B:
        w_retire = (w_state == ST_FETCH);
      default:
        w_retire = 1'b0;
    endcase
  end

  // Saturating retired-instruction counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_retired_cnt <= 16'd0;
    end else if (w_retire && (r_retired_cnt != 16'hFFFF)) begin
      r_retired_cnt <= r_retired_cnt + 16'd1;
    end else begin
      r_retired_cnt <= r_retired_cnt;
    end
  end

  assign retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_proc_controller_gen.sv
// Bench for proc_controller_gen at default parameters. A transaction-level
// model expands each instruction into the per-cycle outputs it should produce
// (plus the inputs to drive in that cycle); a player drives and compares.
module tb_proc_controller_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        alu_zero, start;
  logic        ld, pc_clr, pc_up, pc_ld, d_wr, rf_w_wr, rf_ra_rd, rf_rb_rd;
  logic        halted, error;
  logic [7:0]  pc_ld_val, d_addr, imm;
  logic [1:0]  rf_s;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state_o;
  logic [2:0]  alu_s;
`ifdef CTRL_RETIRE_CNT_EN
  logic [15:0] retired_cnt;
`endif

  proc_controller_gen dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .alu_zero(alu_zero), .start(start), .ld(ld), .pc_clr(pc_clr),
    .pc_up(pc_up), .pc_ld(pc_ld), .pc_ld_val(pc_ld_val), .d_addr(d_addr),
    .d_wr(d_wr), .rf_s(rf_s), .imm(imm), .rf_w_addr(rf_w_addr),
    .rf_w_wr(rf_w_wr), .rf_ra_addr(rf_ra_addr), .rf_ra_rd(rf_ra_rd),
    .rf_rb_addr(rf_rb_addr), .rf_rb_rd(rf_rb_rd), .alu_s(alu_s),
    .halted(halted), .error(error), .state_o(state_o)
`ifdef CTRL_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] en;
    bit          cd, ci, cp, cw, ca, cb;
    logic [7:0]  d_addr, imm, pcv;
    logic [3:0]  wa, ra, rb;
    logic [15:0] instr;
    logic        rst, zero, start;
    logic [15:0] retired;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] cur_instr = 16'h0000;
  bit          jump_pend = 1'b0;
  logic [7:0]  jump_tgt = 8'h00;
  logic [15:0] retired = 16'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  // {0, ld, pc_clr, pc_up, pc_ld, d_wr, rf_s[1:0], rf_w_wr, ra_rd, rb_rd, alu_s[2:0], halted, error}
  function automatic logic [15:0] en_v(input logic l, input logic clr, input logic up,
      input logic pld, input logic dw, input logic [1:0] s, input logic ww,
      input logic rar, input logic rbr, input logic [2:0] as, input logic h, input logic e);
    return {1'b0, l, clr, up, pld, dw, s, ww, rar, rbr, as, h, e};
  endfunction

  task automatic new_cyc(input logic [3:0] st, input logic [15:0] en);
    cur = '{st: st, en: en, cd: 1'b0, ci: 1'b0, cp: 1'b0, cw: 1'b0, ca: 1'b0, cb: 1'b0,
            d_addr: 8'h00, imm: 8'h00, pcv: 8'h00, wa: 4'h0, ra: 4'h0, rb: 4'h0,
            instr: cur_instr, rst: 1'b0, zero: 1'($urandom_range(0, 1)),
            start: 1'($urandom_range(0, 1)), retired: retired};
  endtask

  // Reset state followed by INIT_CYCLES of pc_clr; addresses all cleared
  task automatic push_reset_seq();
    retired = 16'd0;
    jump_pend = 1'b0;
    new_cyc(4'd0, 16'h0000);
    cur.cd = 1'b1; cur.ci = 1'b1; cur.cp = 1'b1; cur.cw = 1'b1; cur.ca = 1'b1; cur.cb = 1'b1;
    q.push_back(cur);
    for (int i = 0; i < 2; i++) begin
      new_cyc(4'd0, en_v(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 0, 0));
      q.push_back(cur);
    end
  endtask

  // Assert reset during the most recently queued cycle
  task automatic mid_reset();
    exp_t e;
    e = q.pop_back();
    e.rst = 1'b1;
    q.push_back(e);
    push_reset_seq();
  endtask

  task automatic do_instr(input logic [15:0] ins, input bit z, input int hc);
    logic [3:0] op, ra, rb, rd;
    logic [7:0] ahi, alo;
    op = ins[15:12]; ra = ins[11:8]; rb = ins[7:4]; rd = ins[3:0];
    ahi = ins[11:4]; alo = ins[7:0];
    cur_instr = ins;
    new_cyc(4'd1, en_v(1, 0, 1, jump_pend, 0, 2'd0, 0, 0, 0, 3'd0, 0, 0));
    cur.cp = jump_pend; cur.pcv = jump_tgt;
    q.push_back(cur);
    jump_pend = 1'b0;
    new_cyc(4'd2, 16'h0000);
    q.push_back(cur);
    case (op)
      4'd0: begin new_cyc(4'd3, 16'h0000); q.push_back(cur); end
      4'd1: begin
        new_cyc(4'd6, en_v(0, 0, 0, 0, 1, 2'd0, 0, 1, 0, 3'd0, 0, 0));
        cur.ca = 1'b1; cur.ra = ra; cur.cd = 1'b1; cur.d_addr = alo;
        q.push_back(cur);
      end
      4'd2: begin
        for (int i = 0; i < 2; i++) begin
          new_cyc(4'(4 + i), en_v(0, 0, 0, 0, 0, 2'd1, 1'(i), 0, 0, 3'd0, 0, 0));
          cur.cd = 1'b1; cur.d_addr = ahi; cur.cw = 1'b1; cur.wa = rd;
          q.push_back(cur);
        end
      end
      4'd3, 4'd4: begin
        new_cyc((op == 4'd3) ? 4'd7 : 4'd8,
                en_v(0, 0, 0, 0, 0, 2'd0, 1, 1, 1, (op == 4'd3) ? 3'd1 : 3'd2, 0, 0));
        cur.ca = 1'b1; cur.ra = ra; cur.cb = 1'b1; cur.rb = rb; cur.cw = 1'b1; cur.wa = rd;
        q.push_back(cur);
      end
      4'd5: begin
        for (int i = 0; i < hc; i++) begin
          new_cyc(4'd9, en_v(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 1, 0));
          cur.start = (i == hc - 1);
          q.push_back(cur);
        end
      end
      4'd6: begin
        new_cyc(4'd10, en_v(0, 0, 0, 0, 0, 2'd2, 1, 0, 0, 3'd0, 0, 0));
        cur.ci = 1'b1; cur.imm = ahi; cur.cw = 1'b1; cur.wa = rd;
        q.push_back(cur);
      end
      4'd7: begin
        new_cyc(4'd11, en_v(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 3'd0, 0, 0));
        cur.ca = 1'b1; cur.ra = ra;
        q.push_back(cur);
        new_cyc(4'd12, en_v(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 3'd0, 0, 0));
        cur.ca = 1'b1; cur.ra = ra; cur.zero = z;
        q.push_back(cur);
        jump_pend = z;
        jump_tgt = alo;
      end
      default: begin
        for (int i = 0; i < 5; i++) begin
          new_cyc(4'd13, en_v(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 0, 1));
          q.push_back(cur);
        end
      end
    endcase
    if ((op <= 4'd7) && (op != 4'd5) && (retired != 16'hFFFF)) retired = retired + 16'd1;
  endtask

  task automatic play();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clock);
      #1;
      reset = e.rst; instruction = e.instr; alu_zero = e.zero; start = e.start;
      @(negedge clock);
      cyc++;
      check_val("state", 32'(state_o), 32'(e.st));
      check_val("ctrl", 32'({1'b0, ld, pc_clr, pc_up, pc_ld, d_wr, rf_s, rf_w_wr,
                             rf_ra_rd, rf_rb_rd, alu_s, halted, error}), 32'(e.en));
      check_val("wr_conflict", 32'(d_wr & rf_w_wr), 32'd0);
      if (e.cd) check_val("d_addr", 32'(d_addr), 32'(e.d_addr));
      if (e.ci) check_val("imm", 32'(imm), 32'(e.imm));
      if (e.cp) check_val("pc_ld_val", 32'(pc_ld_val), 32'(e.pcv));
      if (e.cw) check_val("rf_w_addr", 32'(rf_w_addr), 32'(e.wa));
      if (e.ca) check_val("rf_ra_addr", 32'(rf_ra_addr), 32'(e.ra));
      if (e.cb) check_val("rf_rb_addr", 32'(rf_rb_addr), 32'(e.rb));
`ifdef CTRL_RETIRE_CNT_EN
      check_val("retired_cnt", 32'(retired_cnt), 32'(e.retired));
`endif
    end
  endtask

  initial begin
    logic [3:0] op;
    reset = 1'b1; instruction = 16'h0000; alu_zero = 1'b0; start = 1'b0;
    repeat (2) @(posedge clock);
    push_reset_seq();
    do_instr(16'h2A53, 1'b0, 1);
    do_instr(16'h3127, 1'b0, 1);
    do_instr(16'h4127, 1'b0, 1);
    do_instr(16'h7340, 1'b1, 1);
    do_instr(16'h0000, 1'b0, 1);
    do_instr(16'h7340, 1'b0, 1);
    do_instr(16'h6FF2, 1'b0, 1);
    do_instr(16'h5000, 1'b0, 11);
    do_instr(16'h1234, 1'b0, 1);
    do_instr(16'h3127, 1'b0, 1);
    mid_reset();
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 7));
      do_instr({op, 12'($urandom)}, 1'($urandom_range(0, 1)), $urandom_range(1, 4));
    end
    do_instr(16'h9000, 1'b0, 1);
    mid_reset();
    op = 4'($urandom_range(8, 15));
    do_instr({op, 12'($urandom)}, 1'b0, 1);
    mid_reset();
    do_instr(16'h6AB5, 1'b0, 1);
    do_instr(16'h0000, 1'b0, 1);
    play();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
